// File: rtl/shift_ex_pkg.sv
// Shared types and funct encodings for the Mini-MIPS execute-stage shift unit.
// Build option: SHIFT_EX_ROTATE_EN enables the rotr/rotrv forms of srl/srlv.
package shift_ex_pkg;

   localparam int SHIFT_DW = 32;
   localparam int SHIFT_AW = 5;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;

   typedef enum logic [2:0] {
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_ROR,
      OP_ILL
   } shift_op_t;

   typedef struct packed {
      shift_op_t               op;
      logic [SHIFT_AW-1:0]     amt;
      logic [SHIFT_DW-1:0]     data;
      logic [4:0]              rd;
   } s1_entry_t;

   function automatic logic [SHIFT_DW-1:0] rev32(input logic [SHIFT_DW-1:0] x);
      logic [SHIFT_DW-1:0] r;
      for (int i = 0; i < SHIFT_DW; i++) r[i] = x[SHIFT_DW-1-i];
      return r;
   endfunction

endpackage

// File: rtl/shift_datapath_32.sv
// Combinational 32-bit shifter: one left barrel core, right shifts via bit reversal.
// Build option: SHIFT_EX_ROTATE_EN adds the rotate-right OR path.
module shift_datapath_32
   import shift_ex_pkg::*;
(
   input  shift_op_t             op_i,
   input  logic [SHIFT_AW-1:0]   amt_i,
   input  logic [SHIFT_DW-1:0]   data_i,
   output logic [SHIFT_DW-1:0]   result_o
);

   function automatic logic [SHIFT_DW-1:0] barrel_left(input logic [SHIFT_DW-1:0] x,
                                                       input logic [SHIFT_AW-1:0] a);
      logic [SHIFT_DW-1:0] s;
      s = x;
      s = a[0] ? {s[30:0], 1'b0}  : s;
      s = a[1] ? {s[29:0], 2'b0}  : s;
      s = a[2] ? {s[27:0], 4'b0}  : s;
      s = a[3] ? {s[23:0], 8'b0}  : s;
      s = a[4] ? {s[15:0], 16'b0} : s;
      return s;
   endfunction

   logic [SHIFT_DW-1:0] core_in;
   logic [SHIFT_DW-1:0] core_out;
   logic [SHIFT_DW-1:0] right_out;
   logic [SHIFT_DW-1:0] fill_mask;
`ifdef SHIFT_EX_ROTATE_EN
   logic [SHIFT_DW-1:0] wrap_out;
`endif

   always_comb begin
      core_in   = (op_i == OP_SLL) ? data_i : rev32(data_i);
      core_out  = barrel_left(core_in, amt_i);
      right_out = rev32(core_out);
      // Ones in the top amt bits: complement of an all-ones word shifted right by amt.
      fill_mask = ~rev32(barrel_left('1, amt_i));
`ifdef SHIFT_EX_ROTATE_EN
      // 32-amt taken modulo 32 so amt=0 ORs rt with itself.
      wrap_out  = barrel_left(data_i, SHIFT_AW'(5'd0 - amt_i));
`endif
   end

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_SLL:  result_o = core_out;
         OP_SRL:  result_o = right_out;
         OP_SRA:  result_o = right_out | (data_i[SHIFT_DW-1] ? fill_mask : '0);
`ifdef SHIFT_EX_ROTATE_EN
         OP_ROR:  result_o = right_out | wrap_out;
`endif
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/shift_ex_stage.sv
// Two-stage valid/ready execute shift unit: S1 holds the decoded entry, S2 the result.
// Build option: SHIFT_EX_ROTATE_EN maps srl/srlv with the select bit to rotr/rotrv.
module shift_ex_stage
   import shift_ex_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         in_funct,
   input  logic [DATA_W-1:0]  in_rs_val,
   input  logic [DATA_W-1:0]  in_rt_val,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [4:0]         in_rs_fld,
   input  logic [4:0]         in_rd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_result,
   output logic [4:0]         out_rd,
   output logic               out_illegal
);

   shift_op_t            op_in;
   logic [SHAMT_W-1:0]   amt_in;
   logic                 unused_bits;

   s1_entry_t            s1_q, s1_d;
   logic                 s1_valid_q, s1_valid_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0]    result_q, result_d;
   logic [4:0]           rd_q, rd_d;
   logic                 illegal_q, illegal_d;

   logic                 s2_adv;
   logic                 accept;
   logic [DATA_W-1:0]    dp_result;

   assign unused_bits = ^{in_rs_val[DATA_W-1:SHAMT_W], in_rs_fld};

   always_comb begin
      op_in  = OP_ILL;
      amt_in = in_shamt;
      case (in_funct)
         FN_SLL: op_in = OP_SLL;
         FN_SRL: begin
            op_in = OP_SRL;
`ifdef SHIFT_EX_ROTATE_EN
            if (in_rs_fld[0]) op_in = OP_ROR;
`endif
         end
         FN_SRA: op_in = OP_SRA;
         FN_SLLV: begin
            op_in  = OP_SLL;
            amt_in = in_rs_val[SHAMT_W-1:0];
         end
         FN_SRLV: begin
            op_in  = OP_SRL;
            amt_in = in_rs_val[SHAMT_W-1:0];
`ifdef SHIFT_EX_ROTATE_EN
            if (in_shamt[0]) op_in = OP_ROR;
`endif
         end
         FN_SRAV: begin
            op_in  = OP_SRA;
            amt_in = in_rs_val[SHAMT_W-1:0];
         end
         default: op_in = OP_ILL;
      endcase
   end

   assign s2_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;
   assign accept   = in_valid && in_ready;

   shift_datapath_32 u_dp (
      .op_i     (s1_q.op),
      .amt_i    (s1_q.amt),
      .data_i   (s1_q.data),
      .result_o (dp_result)
   );

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      rd_d       = rd_q;
      illegal_d  = illegal_q;

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d  = dp_result;
            rd_d      = s1_q.rd;
            illegal_d = (s1_q.op == OP_ILL);
         end
      end

      if (in_ready) s1_valid_d = in_valid;
      if (accept) begin
         s1_d.op   = op_in;
         s1_d.amt  = amt_in;
         s1_d.data = in_rt_val;
         s1_d.rd   = in_rd;
      end

      // Kill wins over both accept and advance.
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   // ---- S1: decoded entry ----
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
      end
   end

   // ---- S2: registered result ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         rd_q       <= '0;
         illegal_q  <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         rd_q       <= rd_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = result_q;
   assign out_rd      = rd_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage; honours SHIFT_EX_ROTATE_EN for rotate expectations.
module tb_shift_ex_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [31:0] in_rs_val;
   logic [31:0] in_rt_val;
   logic [4:0]  in_shamt;
   logic [4:0]  in_rs_fld;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   shift_ex_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_funct    (in_funct),
      .in_rs_val   (in_rs_val),
      .in_rt_val   (in_rt_val),
      .in_shamt    (in_shamt),
      .in_rs_fld   (in_rs_fld),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sh, input logic [4:0] fld, input logic [4:0] rd);
      in_funct  = f;
      in_rs_val = rs;
      in_rt_val = rt;
      in_shamt  = sh;
      in_rs_fld = fld;
      in_rd     = rd;
   endtask

   // Issue one op into an empty pipe with out_ready high; report latency and outputs.
   task automatic exec_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [4:0] sh, input logic [4:0] fld, input logic [4:0] rd,
                          output logic [31:0] res, output logic ill, output logic [4:0] ord,
                          output int lat);
      lat = -1;
      res = '0;
      ill = 1'b0;
      ord = '0;
      out_ready = 1'b1;
      drive(f, rs, rt, sh, fld, rd);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (out_valid) begin
            lat = c;
            res = out_result;
            ill = out_illegal;
            ord = out_rd;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h want 00000000", out_result); end
      n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
      n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal: got %b want 0", out_illegal); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_sll;
      logic [31:0] res; logic ill; logic [4:0] ord; int lat;
      exec_op(6'b000000, 32'h0, 32'h0000_0001, 5'd31, 5'd0, 5'd9, res, ill, ord, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sll_latency: got %0d want 2", lat); end
      n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL sll_result: got %h want 80000000", res); end
      n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL sll_illegal: got %b want 0", ill); end
      n_checks++; if (ord !== 5'd9) begin n_fail++; $display("FAIL sll_rd: got %0d want 9", ord); end
   endtask

   task automatic test_variable;
      logic [31:0] res; logic ill; logic [4:0] ord; int lat;
      exec_op(6'b000111, 32'hFFFF_FFE4, 32'hF000_0000, 5'd8, 5'd0, 5'd3, res, ill, ord, lat);
      n_checks++; if (res !== 32'hFF00_0000) begin n_fail++; $display("FAIL srav_result: got %h want ff000000", res); end
      exec_op(6'b000110, 32'hFFFF_FFE4, 32'hF000_0000, 5'd8, 5'd0, 5'd4, res, ill, ord, lat);
      n_checks++; if (res !== 32'h0F00_0000) begin n_fail++; $display("FAIL srlv_result: got %h want 0f000000", res); end
      exec_op(6'b000100, 32'h0000_0023, 32'h0000_0001, 5'd8, 5'd0, 5'd5, res, ill, ord, lat);
      n_checks++; if (res !== 32'h0000_0008) begin n_fail++; $display("FAIL sllv_result: got %h want 00000008", res); end
   endtask

   task automatic test_edges;
      logic [31:0] res; logic ill; logic [4:0] ord; int lat;
      exec_op(6'b000011, 32'h0, 32'h8000_0000, 5'd31, 5'd0, 5'd1, res, ill, ord, lat);
      n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31_result: got %h want ffffffff", res); end
      exec_op(6'b000010, 32'h0, 32'h8000_0000, 5'd31, 5'd0, 5'd1, res, ill, ord, lat);
      n_checks++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL srl31_result: got %h want 00000001", res); end
      exec_op(6'b000011, 32'h0, 32'h8000_0001, 5'd0, 5'd0, 5'd1, res, ill, ord, lat);
      n_checks++; if (res !== 32'h8000_0001) begin n_fail++; $display("FAIL sra0_result: got %h want 80000001", res); end
      exec_op(6'b000111, 32'hFFFF_FFE0, 32'h8765_4321, 5'd6, 5'd0, 5'd1, res, ill, ord, lat);
      n_checks++; if (res !== 32'h8765_4321) begin n_fail++; $display("FAIL srav0_result: got %h want 87654321", res); end
      exec_op(6'b000011, 32'h0, 32'h4000_0000, 5'd30, 5'd0, 5'd1, res, ill, ord, lat);
      n_checks++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL sra_pos_result: got %h want 00000001", res); end
   endtask

   task automatic test_illegal;
      logic [31:0] res; logic ill; logic [4:0] ord; int lat;
      exec_op(6'b100000, 32'h1234_5678, 32'hDEAD_BEEF, 5'd3, 5'd0, 5'd7, res, ill, ord, lat);
      n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL illegal_result: got %h want 00000000", res); end
      n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", ill); end
      n_checks++; if (ord !== 5'd7) begin n_fail++; $display("FAIL illegal_rd: got %0d want 7", ord); end
   endtask

   task automatic test_rotate;
      logic [31:0] res; logic ill; logic [4:0] ord; int lat;
      logic [31:0] exp_a, exp_b;
`ifdef SHIFT_EX_ROTATE_EN
      exp_a = 32'h8000_0000;
      exp_b = 32'hF000_0000;
`else
      exp_a = 32'h0000_0000;
      exp_b = 32'h0000_0000;
`endif
      exec_op(6'b000010, 32'h0, 32'h0000_0001, 5'd1, 5'd1, 5'd2, res, ill, ord, lat);
      n_checks++; if (res !== exp_a) begin n_fail++; $display("FAIL rotr_result: got %h want %h", res, exp_a); end
      exec_op(6'b000110, 32'h0000_0004, 32'h0000_000F, 5'd1, 5'd0, 5'd2, res, ill, ord, lat);
      n_checks++; if (res !== exp_b) begin n_fail++; $display("FAIL rotrv_result: got %h want %h", res, exp_b); end
   endtask

   task automatic test_back_to_back;
      logic [5:0]  vf  [4] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100};
      logic [31:0] vrs [4] = '{32'h0, 32'h0, 32'h0, 32'h0000_0023};
      logic [31:0] vrt [4] = '{32'h0000_0003, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
      logic [4:0]  vsh [4] = '{5'd4, 5'd31, 5'd31, 5'd0};
      logic [31:0] vexp[4] = '{32'h0000_0030, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0008};
      logic [31:0] got_res[4];
      logic [4:0]  got_rd [4];
      int idx = 0;
      int got_n = 0;
      logic took;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         if (idx < 4) begin
            drive(vf[idx], vrs[idx], vrt[idx], vsh[idx], 5'd0, 5'(idx + 1));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready c=%0d: got %b want 0", c, in_ready); end
            n_checks++; if (out_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_stall_hold_rd c=%0d: got %0d want 2", c, out_rd); end
         end
         if (out_valid && out_ready && got_n < 4) begin
            got_res[got_n] = out_result;
            got_rd[got_n]  = out_rd;
            got_n++;
         end
         took = in_valid && in_ready;
         @(posedge clk);
         if (took) idx++;
         @(negedge clk);
         if (got_n == 4 && idx == 4) break;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got_n); end
      for (int i = 0; i < 4; i++) begin
         if (i < got_n) begin
            n_checks++; if (got_rd[i] !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, got_rd[i], i + 1); end
            n_checks++; if (got_res[i] !== vexp[i]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got_res[i], vexp[i]); end
         end
      end
      repeat (3) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_duplicate: got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_flush;
      int extra = 0;
      out_ready = 1'b0;
      drive(6'b000000, 32'h0, 32'h1, 5'd1, 5'd0, 5'd11);
      in_valid = 1'b1;
      @(negedge clk);
      drive(6'b000000, 32'h0, 32'h1, 5'd2, 5'd0, 5'd12);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_prefill: got out_valid %b want 1", out_valid); end
      drive(6'b000000, 32'h0, 32'h1, 5'd3, 5'd0, 5'd13);
      flush = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_next_cycle: got out_valid %b want 0", out_valid); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL flush_no_late_valid: got %0d valid cycles want 0", extra); end
   endtask

   task automatic test_reset_midflight;
      int extra = 0;
      out_ready = 1'b0;
      drive(6'b000000, 32'h0, 32'h5, 5'd1, 5'd0, 5'd20);
      in_valid = 1'b1;
      @(negedge clk);
      drive(6'b000000, 32'h0, 32'h5, 5'd2, 5'd0, 5'd21);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_prefill: got out_valid %b want 1", out_valid); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got out_valid %b want 0", out_valid); end
      n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h want 00000000", out_result); end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL midreset_no_late_valid: got %0d valid cycles want 0", extra); end
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drive(6'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      repeat (2) @(negedge clk);
      test_reset;
      reset = 1'b0;
      @(negedge clk);
      test_sll;
      test_variable;
      test_edges;
      test_illegal;
      test_rotate;
      test_back_to_back;
      test_flush;
      test_reset_midflight;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
